// File: rtl/bcd_display_seq_pkg.sv
// Shared types, segment constants and the double-dabble digit correction
// used by the sequential BCD display path.
package bcd_display_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // A digit of 5 or more would exceed 9 after doubling, so pre-add 3.
    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_display_seq_seg7_digit_dec.sv
// One active-low 7-segment digit decoder (a at bit 6, g at bit 0).
// Dash overrides blank, which overrides the numeric pattern.
module seg7_digit_dec
    import bcd_display_seq_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // Priority select followed by the 0-9 pattern table.
    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = 7'b0000001;
                4'd1:    seg = 7'b1001111;
                4'd2:    seg = 7'b0010010;
                4'd3:    seg = 7'b0000110;
                4'd4:    seg = 7'b1001100;
                4'd5:    seg = 7'b0100100;
                4'd6:    seg = 7'b0100000;
                4'd7:    seg = 7'b0001111;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0001100;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_seq.sv
// Sequential binary-to-BCD converter (one bit per clock) driving registered
// active-low 7-segment digits with sign, leading-zero blanking and overflow.
module bcd_display_seq
    import bcd_display_seq_pkg::*;
#(
    parameter int W        = 16,
    parameter int DIGITS   = 5,
    parameter int SIGNED   = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  minus_n,
    output logic                  ovf
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;

    state_t              state_r;
    state_t              state_next_s;
    logic [W-1:0]        mag_r;
    logic [BW-1:0]       acc_r;
    logic [CW-1:0]       cnt_r;
    logic                neg_r;
    logic                ovf_int_r;
    logic                busy_r;
    logic                done_r;
    logic [BW-1:0]       bcd_r;
    logic [7*DIGITS-1:0] seg_r;
    logic                minus_n_r;
    logic                ovf_r;

    logic                neg_in_s;
    logic [W-1:0]        mag_in_s;
    logic [BW-1:0]       acc_adj_s;
    logic [DIGITS-1:0]   upper_nz_s;
    logic [DIGITS-1:0]   blank_s;
    logic [7*DIGITS-1:0] seg_dec_s;

    // Magnitude of the operand; the most negative value maps to 2^(W-1) exactly.
    always_comb begin
        neg_in_s = (SIGNED != 0) && value[W-1];
        if (neg_in_s) begin
            mag_in_s = ~value + W'(1);
        end else begin
            mag_in_s = value;
        end
    end

    // Add-3 correction on every digit ahead of the shift.
    always_comb begin
        acc_adj_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            acc_adj_s[4*i +: 4] = add3(acc_r[4*i +: 4]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign upper_nz_s[gi] = |acc_r[BW-1:4*gi];
            assign blank_s[gi]    = (BLANK_LZ != 0) && (gi != 0) && !upper_nz_s[gi];

            seg7_digit_dec u_dec (
                .digit (acc_r[4*gi +: 4]),
                .blank (blank_s[gi]),
                .dash  (ovf_int_r),
                .seg   (seg_dec_s[7*gi +: 7])
            );
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the last shift happens while the counter reads 1.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CW'(1)) begin
                    state_next_s = FINISH;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            FINISH:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Conversion datapath and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_r     <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            neg_r     <= 1'b0;
            ovf_int_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bcd_r     <= '0;
            seg_r     <= {DIGITS{SEG_BLANK}};
            minus_n_r <= 1'b1;
            ovf_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mag_r     <= mag_in_s;
                        neg_r     <= neg_in_s;
                        acc_r     <= '0;
                        ovf_int_r <= 1'b0;
                        cnt_r     <= CW'(W);
                        busy_r    <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc_r     <= {acc_adj_s[BW-2:0], mag_r[W-1]};
                    mag_r     <= {mag_r[W-2:0], 1'b0};
                    cnt_r     <= cnt_r - CW'(1);
                    ovf_int_r <= ovf_int_r | acc_adj_s[BW-1];
                end
                FINISH: begin
                    bcd_r     <= acc_r;
                    ovf_r     <= ovf_int_r;
                    minus_n_r <= ~neg_r;
                    seg_r     <= seg_dec_s;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bcd     = bcd_r;
    assign seg     = seg_r;
    assign minus_n = minus_n_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_bcd_display_seq.sv
// Directed bench for bcd_display_seq: a default signed 5-digit instance and
// an unsigned 3-digit instance, plus handshake and reset corner sequences.
module tb_bcd_display_seq;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0001100;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b1111110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] value_a = 16'd0, value_b = 16'd0;
    logic        busy_a, done_a, minus_n_a, ovf_a;
    logic        busy_b, done_b, minus_n_b, ovf_b;
    logic [19:0] bcd_a;
    logic [34:0] seg_a;
    logic [11:0] bcd_b;
    logic [20:0] seg_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_display_seq dut_a (
        .clk(clk), .rst(rst), .start(start_a), .value(value_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .seg(seg_a),
        .minus_n(minus_n_a), .ovf(ovf_a)
    );

    bcd_display_seq #(.W(16), .DIGITS(3), .SIGNED(0), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .value(value_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .seg(seg_b),
        .minus_n(minus_n_b), .ovf(ovf_b)
    );

    typedef struct {
        logic        sel;      // 0 = default instance, 1 = unsigned 3-digit
        logic [15:0] value;
        logic [19:0] bcd;
        logic [34:0] seg;
        logic        minus_n;
        logic        ovf;
        logic        chk_bcd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic convert(input logic sel, input logic [15:0] v, output int lat);
        @(negedge clk);
        if (sel) begin
            value_b = v;
            start_b = 1'b1;
        end else begin
            value_a = v;
            start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        value_a = ~v;
        value_b = ~v;
        chk("busy_after_start", 64'(sel ? busy_b : busy_a), 64'd1);
        lat = 0;
        while ((sel ? done_b : done_a) !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int first;
        int second;

        vecs[0]  = '{1'b0, 16'd1234, 20'h01234, {BL, S1, S2, S3, S4}, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 16'hFFFF, 20'h00001, {BL, BL, BL, BL, S1}, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h8000, 20'h32768, {S3, S2, S7, S6, S8}, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 20'h00000, {BL, BL, BL, BL, S0}, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 16'h7FFF, 20'h32767, {S3, S2, S7, S6, S7}, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 16'hFC18, 20'h01000, {BL, S1, S0, S0, S0}, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 16'd100,  20'h00100, {BL, BL, S1, S0, S0}, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 16'd1000, 20'h00000, 35'({DA, DA, DA}),    1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'd999,  20'h00999, 35'({S9, S9, S9}),    1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 16'hFFFF, 20'h00000, 35'({DA, DA, DA}),    1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'd42,   20'h00042, 35'({BL, S4, S2}),    1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 16'd0,    20'h00000, 35'({BL, BL, S0}),    1'b1, 1'b0, 1'b1};

        // Reset state of both instances.
        #12;
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_done_a", 64'(done_a), 64'd0);
        chk("rst_bcd_a", 64'(bcd_a), 64'd0);
        chk("rst_seg_a", 64'(seg_a), 64'h7_FFFF_FFFF);
        chk("rst_minus_a", 64'(minus_n_a), 64'd1);
        chk("rst_ovf_a", 64'(ovf_a), 64'd0);
        chk("rst_seg_b", 64'(seg_b), 64'h1F_FFFF);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].sel, vecs[i].value, lat);
            chk("latency", 64'(lat), 64'd17);
            if (vecs[i].sel) begin
                chk("busy_at_done_b", 64'(busy_b), 64'd0);
                if (vecs[i].chk_bcd) chk("bcd_b", 64'(bcd_b), 64'(vecs[i].bcd[11:0]));
                chk("seg_b", 64'(seg_b), 64'(vecs[i].seg[20:0]));
                chk("minus_b", 64'(minus_n_b), 64'(vecs[i].minus_n));
                chk("ovf_b", 64'(ovf_b), 64'(vecs[i].ovf));
            end else begin
                chk("busy_at_done_a", 64'(busy_a), 64'd0);
                chk("bcd_a", 64'(bcd_a), 64'(vecs[i].bcd));
                chk("seg_a", 64'(seg_a), 64'(vecs[i].seg));
                chk("minus_a", 64'(minus_n_a), 64'(vecs[i].minus_n));
                chk("ovf_a", 64'(ovf_a), 64'(vecs[i].ovf));
            end
            @(posedge clk);
            #1;
            chk("done_one_cycle", 64'(vecs[i].sel ? done_b : done_a), 64'd0);
        end

        // start re-pulsed mid-conversion must be ignored.
        @(negedge clk);
        value_a = 16'hFB2E;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) start_a = 1'b1;
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (done_a === 1'b1) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        chk("repulse_done_count", 64'(ndone), 64'd1);
        chk("repulse_done_cycle", 64'(first), 64'd17);
        chk("repulse_bcd", 64'(bcd_a), 64'h01234);
        chk("repulse_minus", 64'(minus_n_a), 64'd0);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        value_a = 16'd9999;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        chk("abort_seg", 64'(seg_a), 64'h7_FFFF_FFFF);
        chk("abort_bcd", 64'(bcd_a), 64'd0);
        chk("abort_minus", 64'(minus_n_a), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done_a === 1'b1 || busy_a === 1'b1) ndone++;
        end
        chk("abort_no_activity", 64'(ndone), 64'd0);

        convert(1'b0, 16'd321, lat);
        chk("post_rst_latency", 64'(lat), 64'd17);
        chk("post_rst_bcd", 64'(bcd_a), 64'h00321);
        chk("post_rst_seg", 64'(seg_a), 64'({BL, BL, S3, S2, S1}));

        // start held high: back-to-back conversions, second accepted in the done cycle.
        @(negedge clk);
        value_a = 16'd77;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        first = 0;
        second = 0;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk);
            #1;
            if (c == 35) start_a = 1'b0;
            if (done_a === 1'b1) begin
                ndone++;
                if (first == 0) first = c;
                else second = c;
            end
        end
        chk("b2b_done_count", 64'(ndone), 64'd2);
        chk("b2b_first", 64'(first), 64'd17);
        chk("b2b_second", 64'(second), 64'd35);
        chk("b2b_bcd", 64'(bcd_a), 64'h00077);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_idle", 64'(busy_a), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
